csync_vsync_extract: RTL and testbench

- Upstream stage of the PAL/NTSC detector: recovers a clean active-low VSYNC from a raw composite-sync input by classifying low pulse widths.
- Filters glitches, detects runs of broad (vertical-serration) pulses and drives vsync_out, whose falling edge marks field start.
- Also reports sync pulses per field and a loss-of-sync flag for the downstream format logic.

---
 rtl/csync_vsync_extract.sv | 184 ++++++++++++++++++
 tb/tb_csync_vsync_extract.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/csync_vsync_extract.sv
// Recovers a clean active-low vsync from raw composite sync by classifying low-pulse widths.
// Also reports sync pulses per field and a loss-of-sync flag.
module csync_vsync_extract #(
  parameter int unsigned CLK_FREQ    = 2_000_000,
  parameter int unsigned FILTER_LEN  = 3,
  parameter int unsigned BROAD_US    = 15,
  parameter int unsigned BROAD_COUNT = 3,
  parameter int unsigned TIMEOUT_US  = 200
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        csync_in,
  output logic        vsync_out,
  output logic [11:0] pulse_count_out,
  output logic        pulse_count_valid,
  output logic        sync_lost
);

  localparam int unsigned CLKS_PER_US  = CLK_FREQ / 1_000_000;
  localparam int unsigned BROAD_CLKS   = CLKS_PER_US * BROAD_US;
  localparam int unsigned TIMEOUT_CLKS = CLKS_PER_US * TIMEOUT_US;
  localparam int unsigned FILT_W       = 4;
  localparam int unsigned WIDTH_W      = 16;
  localparam int unsigned PCNT_W       = 12;
  localparam int unsigned BCNT_W       = 3;
  localparam int unsigned TMO_W        = $clog2(TIMEOUT_CLKS + 1);

  typedef enum logic [1:0] {
    ST_LOST  = 2'd0,
    ST_LINES = 2'd1,
    ST_VSYNC = 2'd2
  } state_t;

  logic [1:0]         sync_q;
  logic               filt_q;
  logic               filt_d_q;
  logic [FILT_W-1:0]  filt_cnt_q;
  logic [WIDTH_W-1:0] width_q;
  logic [TMO_W-1:0]   tmo_q;

  state_t             state_q, state_d;
  logic [PCNT_W-1:0]  pulse_cnt_q, pulse_cnt_d;
  logic [BCNT_W-1:0]  broad_cnt_q, broad_cnt_d;
  logic               first_field_q, first_field_d;
  logic               vsync_d;
  logic [PCNT_W-1:0]  pcount_d;
  logic               valid_d;
  logic               lost_d;

  logic fall_c, rise_c, broad_c, narrow_c, timeout_c;

  assign fall_c    = filt_d_q & ~filt_q;
  assign rise_c    = ~filt_d_q & filt_q;
  assign broad_c   = rise_c && (width_q >= WIDTH_W'(BROAD_CLKS));
  assign narrow_c  = rise_c && (width_q < WIDTH_W'(BROAD_CLKS));
  assign timeout_c = (tmo_q == TMO_W'(TIMEOUT_CLKS));

  // Synchronizer and glitch filter: level flips only after FILTER_LEN agreeing samples
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync_q     <= 2'b11;
      filt_q     <= 1'b1;
      filt_d_q   <= 1'b1;
      filt_cnt_q <= '0;
    end else begin
      sync_q   <= {sync_q[0], csync_in};
      filt_d_q <= filt_q;
      if (sync_q[1] == filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FILT_W'(FILTER_LEN - 1)) begin
        filt_q     <= sync_q[1];
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + FILT_W'(1);
      end
    end
  end

  // Low-pulse width (in filtered low cycles) and time since the last falling edge
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      width_q <= '0;
      tmo_q   <= '0;
    end else begin
      if (fall_c) begin
        width_q <= WIDTH_W'(1);
      end else if (!filt_q && (width_q != '1)) begin
        width_q <= width_q + WIDTH_W'(1);
      end
      if (fall_c) begin
        tmo_q <= '0;
      end else if (!timeout_c) begin
        tmo_q <= tmo_q + TMO_W'(1);
      end
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q           <= ST_LOST;
      pulse_cnt_q       <= '0;
      broad_cnt_q       <= '0;
      first_field_q     <= 1'b0;
      vsync_out         <= 1'b1;
      pulse_count_out   <= '0;
      pulse_count_valid <= 1'b0;
      sync_lost         <= 1'b1;
    end else begin
      state_q           <= state_d;
      pulse_cnt_q       <= pulse_cnt_d;
      broad_cnt_q       <= broad_cnt_d;
      first_field_q     <= first_field_d;
      vsync_out         <= vsync_d;
      pulse_count_out   <= pcount_d;
      pulse_count_valid <= valid_d;
      sync_lost         <= lost_d;
    end
  end

  // Next state, counters and outputs; timeout overrides every classification
  always_comb begin
    state_d       = state_q;
    pulse_cnt_d   = pulse_cnt_q;
    broad_cnt_d   = broad_cnt_q;
    first_field_d = first_field_q;
    vsync_d       = vsync_out;
    pcount_d      = pulse_count_out;
    valid_d       = 1'b0;
    lost_d        = sync_lost;

    if (fall_c && (pulse_cnt_q != '1)) begin
      pulse_cnt_d = pulse_cnt_q + PCNT_W'(1);
    end
    if (broad_c && (broad_cnt_q != BCNT_W'(BROAD_COUNT))) begin
      broad_cnt_d = broad_cnt_q + BCNT_W'(1);
    end else if (narrow_c) begin
      broad_cnt_d = '0;
    end

    if ((state_q != ST_LOST) && timeout_c) begin
      state_d     = ST_LOST;
      vsync_d     = 1'b1;
      lost_d      = 1'b1;
      pulse_cnt_d = '0;
      broad_cnt_d = '0;
    end else begin
      case (state_q)
        ST_LOST: begin
          pulse_cnt_d = '0;
          broad_cnt_d = '0;
          vsync_d     = 1'b1;
          lost_d      = 1'b1;
          if (fall_c) begin
            state_d       = ST_LINES;
            lost_d        = 1'b0;
            first_field_d = 1'b1;
          end
        end
        ST_LINES: begin
          if (broad_c && (broad_cnt_d == BCNT_W'(BROAD_COUNT))) begin
            state_d       = ST_VSYNC;
            vsync_d       = 1'b0;
            pcount_d      = pulse_cnt_q;
            valid_d       = ~first_field_q;
            first_field_d = 1'b0;
            // An edge coinciding with the load belongs to the new field
            pulse_cnt_d   = fall_c ? PCNT_W'(1) : '0;
          end
        end
        ST_VSYNC: begin
          if (narrow_c) begin
            state_d = ST_LINES;
            vsync_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_LOST;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csync_vsync_extract.sv
// Scoreboard bench for csync_vsync_extract: stimulus pushes expected output events,
// a negedge monitor pops and compares whenever an output changes or strobes.
module tb_csync_vsync_extract;

  localparam int unsigned FILTER_LEN   = 3;
  localparam int unsigned BROAD_CLKS   = 30;
  localparam int unsigned BROAD_COUNT  = 3;
  localparam int unsigned TIMEOUT_CLKS = 400;
  localparam int unsigned EDGE_LAT     = 2 + FILTER_LEN + 1;
  localparam int unsigned TO_LAT       = EDGE_LAT + TIMEOUT_CLKS + 1;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        csync_in;
  logic        vsync_out;
  logic [11:0] pulse_count_out;
  logic        pulse_count_valid;
  logic        sync_lost;

  csync_vsync_extract dut (
    .clk_in            (clk_in),
    .rst_n_in          (rst_n_in),
    .csync_in          (csync_in),
    .vsync_out         (vsync_out),
    .pulse_count_out   (pulse_count_out),
    .pulse_count_valid (pulse_count_valid),
    .sync_lost         (sync_lost)
  );

  always #5 clk_in = ~clk_in;

  typedef enum int unsigned {EV_LOST = 0, EV_VSYNC = 1, EV_VALID = 2} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    int unsigned value;
    int unsigned cyc;
  } ev_t;

  ev_t         exp_q[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          passes = 0;
  int unsigned n_valid = 0;
  int unsigned last_valid = 0;

  // Reference model state
  bit          m_lost = 1'b1;
  bit          m_first = 1'b0;
  bit          m_vs = 1'b0;
  int unsigned m_run = 0;
  int unsigned m_cnt = 0;
  int unsigned m_last_fall = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic push(input ev_kind_t k, input int unsigned v, input int unsigned c);
    ev_t e;
    e.kind  = k;
    e.value = v;
    e.cyc   = c;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_t k, input int unsigned v);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      $display("FAIL unexpected_event: got kind %0d value %0d at cycle %0d, required no event",
               k, v, cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", k, e.kind);
      check("event_value", v, e.value);
      check("event_cycle", cyc, e.cyc);
    end
  endtask

  // Monitor: any change of sync_lost/vsync_out or a valid strobe is an output event
  logic prev_lost, prev_vsync;
  always @(negedge clk_in) begin
    if (!rst_n_in) begin
      prev_lost  = sync_lost;
      prev_vsync = vsync_out;
    end else begin
      if (sync_lost !== prev_lost) observe(EV_LOST, 32'(sync_lost));
      if (vsync_out !== prev_vsync) observe(EV_VSYNC, 32'(vsync_out));
      if (pulse_count_valid) begin
        n_valid++;
        last_valid = 32'(pulse_count_out);
        observe(EV_VALID, 32'(pulse_count_out));
      end
      prev_lost  = sync_lost;
      prev_vsync = vsync_out;
    end
  end

  task automatic model_timeout(input int unsigned horizon);
    if (!m_lost && (m_last_fall + TO_LAT <= horizon)) begin
      push(EV_LOST, 1, m_last_fall + TO_LAT);
      if (m_vs) push(EV_VSYNC, 1, m_last_fall + TO_LAT);
      m_lost = 1'b1;
      m_vs   = 1'b0;
      m_run  = 0;
      m_cnt  = 0;
    end
  endtask

  task automatic wait_clks(input int unsigned n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  // One csync pulse: low for 'low' clocks within a 'period'-clock slot
  task automatic pulse(input int unsigned low, input int unsigned period);
    model_timeout(cyc + EDGE_LAT - 1);
    if (m_lost) begin
      push(EV_LOST, 0, cyc + EDGE_LAT);
      m_lost  = 1'b0;
      m_first = 1'b1;
      m_cnt   = 0;
    end else if (m_cnt < 4095) begin
      m_cnt++;
    end
    m_last_fall = cyc;
    csync_in = 1'b0;
    wait_clks(low);
    csync_in = 1'b1;
    if (!m_lost) begin
      if (low >= BROAD_CLKS) begin
        if (m_run < BROAD_COUNT) m_run++;
        if (!m_vs && (m_run == BROAD_COUNT)) begin
          push(EV_VSYNC, 0, cyc + EDGE_LAT);
          if (!m_first) push(EV_VALID, m_cnt, cyc + EDGE_LAT);
          m_first = 1'b0;
          m_cnt   = 0;
          m_vs    = 1'b1;
        end
      end else begin
        m_run = 0;
        if (m_vs) begin
          push(EV_VSYNC, 1, cyc + EDGE_LAT);
          m_vs = 1'b0;
        end
      end
    end
    wait_clks(period - low);
  endtask

  task automatic idle(input int unsigned n);
    model_timeout(cyc + n);
    csync_in = 1'b1;
    wait_clks(n);
  endtask

  task automatic glitch(input int unsigned len);
    csync_in = 1'b0;
    wait_clks(len);
    csync_in = 1'b1;
    wait_clks(50 - len);
  endtask

  task automatic field(input int unsigned lines, input int unsigned nbroad, input int unsigned neq);
    for (int i = 0; i < int'(lines); i++) pulse(9, 128);
    for (int i = 0; i < int'(nbroad); i++) pulse(54, 64);
    for (int i = 0; i < int'(neq); i++) pulse(5, 64);
  endtask

  initial begin
    rst_n_in = 1'b0;
    csync_in = 1'b1;
    wait_clks(3);
    check("reset_vsync", 32'(vsync_out), 1);
    check("reset_sync_lost", 32'(sync_lost), 1);
    check("reset_count", 32'(pulse_count_out), 0);
    check("reset_valid", 32'(pulse_count_valid), 0);
    rst_n_in = 1'b1;

    idle(400);
    check("idle_sync_lost", 32'(sync_lost), 1);
    check("idle_vsync", 32'(vsync_out), 1);

    for (int i = 0; i < 4; i++) begin
      glitch(1);
      glitch(2);
    end
    check("glitch_sync_lost", 32'(sync_lost), 1);
    check("glitch_valid_count", n_valid, 0);

    // Lock-in field: vsync regenerated but no strobe
    field(10, 5, 5);
    check("first_field_valid_count", n_valid, 0);
    check("first_field_sync_lost", 32'(sync_lost), 0);

    // Full PAL-like field: 2 + 5 + 300 + 3 edges between vsync starts
    field(300, 5, 5);
    check("pal_valid_count", n_valid, 1);
    check("pal_pulse_count", last_valid, 310);

    // Short broad run must not start vsync; the next full run does
    field(10, 2, 5);
    check("short_run_valid_count", n_valid, 1);
    check("short_run_vsync", 32'(vsync_out), 1);
    field(10, 5, 5);
    check("after_short_run_count", last_valid, 37);

    // Loss of sync, then recovery: first field silent, second strobes
    field(5, 0, 0);
    idle(401);
    check("timeout_sync_lost", 32'(sync_lost), 1);
    check("timeout_vsync", 32'(vsync_out), 1);
    field(5, 5, 5);
    check("recovery_first_valid_count", n_valid, 2);
    field(10, 5, 5);
    check("recovery_second_valid_count", n_valid, 3);
    check("recovery_pulse_count", last_valid, 20);

    // Asynchronous reset while vsync_out is low, mid broad pulse
    field(3, 3, 0);
    csync_in = 1'b0;
    wait_clks(20);
    check("pre_reset_vsync", 32'(vsync_out), 0);
    check("pre_reset_count", 32'(pulse_count_out), 13);
    check("pre_reset_queue_empty", 32'(exp_q.size()), 0);
    #2;
    rst_n_in = 1'b0;
    #1;
    check("async_reset_vsync", 32'(vsync_out), 1);
    check("async_reset_sync_lost", 32'(sync_lost), 1);
    check("async_reset_count", 32'(pulse_count_out), 0);
    check("async_reset_valid", 32'(pulse_count_valid), 0);
    csync_in = 1'b1;
    m_lost = 1'b1;
    m_first = 1'b0;
    m_vs = 1'b0;
    m_run = 0;
    m_cnt = 0;
    wait_clks(2);
    rst_n_in = 1'b1;
    idle(50);
    check("post_reset_sync_lost", 32'(sync_lost), 1);
    check("final_queue_empty", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
